// File: rtl/softmax_row_streamer_pkg.sv
// Shared constants and types for the softmax row readback stage.
// Optional row-sum check: SOFTMAX_STREAM_SUM_CHECK_EN.
package softmax_pkg;

    localparam int N       = 32;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = $clog2(N);
    localparam int SUM_W   = DATA_W + $clog2(N);
    localparam int SUM_TOL = 64;

    typedef logic [DATA_W-1:0] row_elem_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } stream_state_t;

endpackage

// File: rtl/softmax_row_streamer_if.sv
// Valid/ready output stream with last-beat marker.
interface softmax_row_streamer_if;
    import softmax_pkg::*;

    row_elem_t tdata;
    logic      tvalid;
    logic      tready;
    logic      tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/softmax_row_streamer_skid_fifo.sv
// Two-entry skid buffer; head is held stable until popped.
module stream_skid_fifo
    import softmax_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       push,
    input  row_elem_t  push_data,
    input  logic       pop,
    output row_elem_t  head,
    output logic [1:0] occ
);

    row_elem_t tail;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            unique case (occ)
                2'd0: begin
                    if (push) begin
                        head <= push_data;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= push_data;
                    end else if (push) begin
                        tail <= push_data;
                        occ  <= 2'd2;
                    end else if (pop) begin
                        occ  <= 2'd0;
                    end
                end
                2'd2: begin
                    // credit rule keeps push off while full
                    if (pop) begin
                        head <= tail;
                        occ  <= 2'd1;
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/softmax_row_streamer.sv
// Reads a finished softmax row from BRAM port B and streams it out.
// Optional row-sum check: SOFTMAX_STREAM_SUM_CHECK_EN.
module softmax_row_streamer
    import softmax_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_rd_en,
    output logic [ADDR_W-1:0]       o_rd_addr,
    input  row_elem_t               i_rd_data,
    softmax_row_streamer_if.master  m_axis,
    output logic                    o_done,
    output logic                    o_sum_err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    stream_state_t     state;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] out_idx;
    logic              inflight;
    logic [1:0]        occ;
    logic              pop;
    logic [2:0]        credit;
    row_elem_t         head;

    assign pop    = m_axis.tvalid && m_axis.tready;
    // slots already claimed once this cycle's pop leaves
    assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign o_rd_en   = (state == READ) && (credit < 3'd2);
    assign o_rd_addr = rd_idx;
    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);

    assign m_axis.tvalid = (occ != 2'd0);
    assign m_axis.tdata  = head;
    assign m_axis.tlast  = m_axis.tvalid && (out_idx == LAST);

    stream_skid_fifo u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (inflight),
        .push_data (i_rd_data),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            rd_idx   <= '0;
            out_idx  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= o_rd_en;
            if (pop && out_idx != LAST) begin
                out_idx <= out_idx + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= READ;
                        rd_idx  <= '0;
                        out_idx <= '0;
                    end
                end
                READ: begin
                    if (o_rd_en) begin
                        if (rd_idx == LAST) begin
                            state <= DRAIN;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_idx == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

`ifdef SOFTMAX_STREAM_SUM_CHECK_EN
    localparam logic [SUM_W-1:0] ONE = SUM_W'(2 ** DATA_W);
    localparam logic [SUM_W-1:0] TOL = SUM_W'(SUM_TOL);

    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] dev;

    assign dev = (acc >= ONE) ? (acc - ONE) : (ONE - acc);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc       <= '0;
            o_sum_err <= 1'b0;
        end else if (state == IDLE && i_start) begin
            acc       <= '0;
            o_sum_err <= 1'b0;
        end else begin
            if (pop) begin
                acc <= acc + SUM_W'(head);
            end
            if (state == DONE) begin
                o_sum_err <= (dev > TOL);
            end
        end
    end
`else
    assign o_sum_err = 1'b0;
`endif

endmodule
